// File: rtl/flash_timer.sv
//==============================================================================
// Module      : flash_timer
// Description : Timing responder for the NOR flash bridge. It accepts a
//               four-phase ft_start/ft_done handshake and counts the flash
//               read access time or the write pulse plus recovery time at
//               50 MHz. It then holds ft_done until the request is withdrawn.
//               Optional macro FLASH_STS_WAIT_EN adds a ready poll of NF_STS,
//               with a timeout, after the write recovery phase.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module flash_timer #(
    parameter int READ_CYCLES    = 6,
    parameter int WRITE_CYCLES   = 4,
    parameter int RECOVER_CYCLES = 2,
    parameter int STS_TIMEOUT    = 50000,
    parameter int CNT_W          = 16
) (
    input  logic CLK_50MHZ,
    input  logic RST,
    input  logic ft_start,
    input  logic direction_rw,
    input  logic NF_STS,
    output logic ft_done,
    output logic ft_timeout,
    output logic ft_busy
);

    // A zero cycle count would make the down-counter wrap, so it is clamped to one.
    localparam int READ_EFF    = (READ_CYCLES    < 1) ? 1 : READ_CYCLES;
    localparam int WRITE_EFF   = (WRITE_CYCLES   < 1) ? 1 : WRITE_CYCLES;
    localparam int RECOVER_EFF = (RECOVER_CYCLES < 1) ? 1 : RECOVER_CYCLES;
    localparam int TIMEOUT_EFF = (STS_TIMEOUT    < 1) ? 1 : STS_TIMEOUT;

    // The counter runs from N-1 down to 0, so each phase lasts N cycles.
    localparam logic [CNT_W-1:0] READ_LOAD    = CNT_W'(READ_EFF - 1);
    localparam logic [CNT_W-1:0] WRITE_LOAD   = CNT_W'(WRITE_EFF - 1);
    localparam logic [CNT_W-1:0] RECOVER_LOAD = CNT_W'(RECOVER_EFF - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_EFF - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ACCESS   = 3'd1,
        RECOVER  = 3'd2,
        STS_WAIT = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             is_read;
    logic             is_read_nxt;
    logic             done_nxt;
    logic             busy_nxt;

`ifdef FLASH_STS_WAIT_EN
    logic sts_meta;
    logic sts_sync;
    logic timeout_q;
    logic timeout_nxt;

    // Two-flop synchronizer for the asynchronous flash status pin.
    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            sts_meta <= 1'b0;
            sts_sync <= 1'b0;
        end else begin
            sts_meta <= NF_STS;
            sts_sync <= sts_meta;
        end
    end

    assign ft_timeout = timeout_q;
`else
    // Without the ready poll, the status pin and the timeout value have no function.
    logic unused_cfg;
    assign unused_cfg = NF_STS ^ (|TIMEOUT_LOAD);
    assign ft_timeout = 1'b0;
`endif

    // State register and registered outputs.
    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            is_read   <= 1'b0;
            ft_done   <= 1'b0;
            ft_busy   <= 1'b0;
`ifdef FLASH_STS_WAIT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            is_read   <= is_read_nxt;
            ft_done   <= done_nxt;
            ft_busy   <= busy_nxt;
`ifdef FLASH_STS_WAIT_EN
            timeout_q <= timeout_nxt;
`endif
        end
    end

    // Next-state logic. Withdrawing ft_start before DONE aborts the access.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        is_read_nxt = is_read;
        done_nxt    = ft_done;
`ifdef FLASH_STS_WAIT_EN
        timeout_nxt = timeout_q;
`endif
        case (state)
            IDLE: begin
                if (ft_start) begin
                    is_read_nxt = direction_rw;
                    cnt_nxt     = direction_rw ? READ_LOAD : WRITE_LOAD;
                    state_nxt   = ACCESS;
`ifdef FLASH_STS_WAIT_EN
                    timeout_nxt = 1'b0;
`endif
                end
            end
            ACCESS: begin
                if (!ft_start) begin
                    state_nxt = IDLE;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else if (is_read) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt   = RECOVER_LOAD;
                    state_nxt = RECOVER;
                end
            end
            RECOVER: begin
                if (!ft_start) begin
                    state_nxt = IDLE;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
`ifdef FLASH_STS_WAIT_EN
                    cnt_nxt   = TIMEOUT_LOAD;
                    state_nxt = STS_WAIT;
`else
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
`endif
                end
            end
            STS_WAIT: begin
`ifdef FLASH_STS_WAIT_EN
                // A ready indication on the final cycle takes priority over a timeout.
                if (!ft_start) begin
                    state_nxt = IDLE;
                end else if (sts_sync) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end else if (cnt == '0) begin
                    state_nxt   = DONE;
                    done_nxt    = 1'b1;
                    timeout_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
`else
                state_nxt = IDLE;
`endif
            end
            DONE: begin
                if (!ft_start) begin
                    done_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                done_nxt  = 1'b0;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

endmodule

`default_nettype wire

// File: tb/tb_flash_timer.sv
//==============================================================================
// Module      : tb_flash_timer
// Description : Self-checking bench for flash_timer. It runs a table of
//               directed transactions, randomized transactions against a
//               latency model, and an asynchronous reset sequence.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_flash_timer;

    localparam int READ_CYC  = 6;
    localparam int WRITE_CYC = 4;
    localparam int REC_CYC   = 2;
    localparam int TIMEOUT   = 20;
    localparam int NEVER     = 1000;
`ifdef FLASH_STS_WAIT_EN
    // Status already high: a single extra cycle in the ready poll.
    localparam int WRITE_LAT = WRITE_CYC + REC_CYC + 1;
`else
    localparam int WRITE_LAT = WRITE_CYC + REC_CYC;
`endif

    logic clk = 1'b0;
    logic rst;
    logic ft_start;
    logic direction_rw;
    logic nf_sts;
    logic ft_done;
    logic ft_timeout;
    logic ft_busy;

    int n_checks = 0;
    int n_fail   = 0;

    flash_timer #(
        .READ_CYCLES   (READ_CYC),
        .WRITE_CYCLES  (WRITE_CYC),
        .RECOVER_CYCLES(REC_CYC),
        .STS_TIMEOUT   (TIMEOUT),
        .CNT_W         (16)
    ) dut (
        .CLK_50MHZ   (clk),
        .RST         (rst),
        .ft_start    (ft_start),
        .direction_rw(direction_rw),
        .NF_STS      (nf_sts),
        .ft_done     (ft_done),
        .ft_timeout  (ft_timeout),
        .ft_busy     (ft_busy)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    // Directed or random transaction:
    //   drop_at  = the edge at which ft_start is first sampled low
    //   lat      = the edge at which ft_done rises (NEVER if it must not rise)
    //   sts_rise = the negedge after edge k at which NF_STS goes high
    typedef struct {
        bit dir;
        int drop_at;
        int lat;
        bit sts_init;
        int sts_rise;
        bit to;
    } vec_t;

    vec_t vecs[$];

    // Edge 0 is the first edge that samples ft_start=1. Outputs are checked
    // at the negedge that follows each edge k.
    task automatic run_txn(input vec_t v, input string tag);
        bit active;
        nf_sts       = v.sts_init;
        ft_start     = 1'b1;
        direction_rw = v.dir;
        for (int k = 0; k <= v.drop_at + 1; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 0) direction_rw = ~v.dir;
            active = (k < v.drop_at);
            check({tag, " busy"}, ft_busy, active);
            check({tag, " done"}, ft_done, active && (k >= v.lat));
            check({tag, " timeout"}, ft_timeout, v.to && (k >= v.lat));
            if (k == v.sts_rise) nf_sts = 1'b1;
            if (k == v.drop_at - 1) ft_start = 1'b0;
        end
    endtask

    function automatic vec_t mk(bit d, int drop, int lat, bit si, int sr, bit to);
        vec_t v;
        v.dir = d; v.drop_at = drop; v.lat = lat;
        v.sts_init = si; v.sts_rise = sr; v.to = to;
        return v;
    endfunction

    initial begin
        vec_t rv;
        rst          = 1'b1;
        ft_start     = 1'b0;
        direction_rw = 1'b0;
        nf_sts       = 1'b1;

        // Directed table.
        vecs.push_back(mk(1'b1, 8,  READ_CYC,  1'b1, -1, 1'b0)); // plain read
        vecs.push_back(mk(1'b0, 8,  WRITE_LAT, 1'b1, -1, 1'b0)); // plain write
        vecs.push_back(mk(1'b1, 4,  NEVER,     1'b1, -1, 1'b0)); // abort read in ACCESS
        vecs.push_back(mk(1'b0, 5,  NEVER,     1'b1, -1, 1'b0)); // abort write in RECOVER
        vecs.push_back(mk(1'b1, 6,  NEVER,     1'b1, -1, 1'b0)); // drop on completion edge
        vecs.push_back(mk(1'b1, 30, READ_CYC,  1'b1, -1, 1'b0)); // held high in DONE
        vecs.push_back(mk(1'b0, 7,  WRITE_LAT, 1'b1, -1, 1'b0)); // drop right after done
`ifdef FLASH_STS_WAIT_EN
        vecs.push_back(mk(1'b0, 16, 13, 1'b0, 10, 1'b0));                // ready after edge 10
        vecs.push_back(mk(1'b0, 28, WRITE_CYC + REC_CYC + TIMEOUT,
                          1'b0, NEVER, 1'b1));                           // status timeout
        vecs.push_back(mk(1'b1, 8,  READ_CYC, 1'b1, -1, 1'b0));          // accept clears timeout
`endif

        #1;
        check("reset busy", ft_busy, 1'b0);
        check("reset done", ft_done, 1'b0);
        check("reset timeout", ft_timeout, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle busy", ft_busy, 1'b0);

        foreach (vecs[i]) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
            @(negedge clk);
        end

        // Randomized transactions against the latency model.
        for (int i = 0; i < 24; i++) begin
            rv.dir      = 1'($urandom % 2);
            rv.lat      = rv.dir ? READ_CYC : WRITE_LAT;
            rv.drop_at  = int'($urandom_range(1, rv.lat + 4));
            rv.sts_init = 1'b1;
            rv.sts_rise = -1;
            rv.to       = 1'b0;
            run_txn(rv, $sformatf("rand%0d", i));
            repeat ($urandom_range(1, 3)) begin
                @(negedge clk);
                check("rand gap busy", ft_busy, 1'b0);
            end
        end

        // Asynchronous reset in the middle of ACCESS.
        ft_start     = 1'b1;
        direction_rw = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async rst busy", ft_busy, 1'b0);
        check("async rst done", ft_done, 1'b0);
        check("async rst timeout", ft_timeout, 1'b0);
        @(negedge clk);
        rst      = 1'b0;
        ft_start = 1'b0;
        @(negedge clk);
        check("post rst idle", ft_busy, 1'b0);
        run_txn(mk(1'b1, 8, READ_CYC, 1'b1, -1, 1'b0), "post rst read");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
